bit_population_accumulator: RTL

BIT_POPULATION_ACCUMULATOR -- requirements
Module: bit_population_accumulator

---
 rtl/bit_population_accumulator.sv | 132 +++++++++++++
 1 files changed

// File: rtl/bit_population_accumulator.sv
// Frame accumulator for upstream population counts: per frame of FRAME_LEN words
// it reports the sum, minimum and maximum count, and flags out-of-range inputs.
module bit_population_accumulator #(
  parameter  int WIDTH     = 8,
  parameter  int FRAME_LEN = 16,
  localparam int CNT_W     = $clog2(WIDTH) + 1,
  localparam int SUM_W     = $clog2(WIDTH * FRAME_LEN + 1)
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] data_i,
  input  logic             data_val_i,
  output logic [SUM_W-1:0] sum_o,
  output logic [CNT_W-1:0] min_o,
  output logic [CNT_W-1:0] max_o,
  output logic             frame_val_o,
  output logic             busy_o,
  output logic             err_o
);

  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] d);
    return (d > MAX_CNT) ? MAX_CNT : d;
  endfunction

  function automatic logic [CNT_W-1:0] min_cnt(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    return (b < a) ? b : a;
  endfunction

  function automatic logic [CNT_W-1:0] max_cnt(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    return (b > a) ? b : a;
  endfunction

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [1:0]       r_rst_sync;
  logic [SUM_W-1:0] r_acc_sum;
  logic [CNT_W-1:0] r_acc_min;
  logic [CNT_W-1:0] r_acc_max;
  logic [SUM_W-1:0] r_sum;
  logic [CNT_W-1:0] r_min;
  logic [CNT_W-1:0] r_max;
  logic             r_frame_val;
  logic             r_err;

  logic             w_accept;
  logic             w_first;
  logic             w_last;
  logic             w_bad;
  logic [CNT_W-1:0] w_cnt;
  logic [SUM_W-1:0] w_new_sum;
  logic [CNT_W-1:0] w_new_min;
  logic [CNT_W-1:0] w_new_max;

  // Reset release is re-timed to clk_i; words are ignored until it has propagated.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) r_rst_sync <= 2'b00;
    else           r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  always_comb begin
    w_accept  = data_val_i & r_rst_sync[1] & ~clear_i;
    w_first   = (r_state == IDLE);
    w_last    = (r_idx == LAST_IDX);
    w_bad     = (data_i > MAX_CNT);
    w_cnt     = sat_cnt(data_i);
    w_new_sum = w_first ? SUM_W'(w_cnt) : r_acc_sum + SUM_W'(w_cnt);
    w_new_min = w_first ? w_cnt : min_cnt(r_acc_min, w_cnt);
    w_new_max = w_first ? w_cnt : max_cnt(r_acc_max, w_cnt);
  end

  // Control and published results.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_sum       <= '0;
      r_min       <= '0;
      r_max       <= '0;
      r_frame_val <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_frame_val <= 1'b0;
      if (clear_i) begin
        r_state <= IDLE;
        r_idx   <= '0;
        r_err   <= 1'b0;
      end else if (w_accept) begin
        if (w_bad) r_err <= 1'b1;
        if (w_last) begin
          r_state     <= IDLE;
          r_idx       <= '0;
          r_sum       <= w_new_sum;
          r_min       <= w_new_min;
          r_max       <= w_new_max;
          r_frame_val <= 1'b1;
        end else begin
          r_state <= ACC;
          r_idx   <= r_idx + 1'b1;
        end
      end
    end
  end

  // Running partials are only read after a first-word load, so they need no reset.
  always_ff @(posedge clk_i) begin
    if (w_accept && !w_last) begin
      r_acc_sum <= w_new_sum;
      r_acc_min <= w_new_min;
      r_acc_max <= w_new_max;
    end
  end

  assign sum_o       = r_sum;
  assign min_o       = r_min;
  assign max_o       = r_max;
  assign frame_val_o = r_frame_val;
  assign busy_o      = (r_state == ACC);
  assign err_o       = r_err;

endmodule
